ram_arbiter: RTL

- Shares the single-port 64-bit data RAM (13-bit word address, 7840 words, synchronous write, registered read) between two requesters, e.g. instruction fetch (port 0) and load/store (port 1).
- Grants at most one access per cycle and drives the RAM address, write-data and write-enable lines.
- Returns read data to the owning port on a registered response channel.
- Range-checks addresses against the RAM depth so out-of-range accesses never corrupt memory.

---
 rtl/ram_arbiter_pkg.sv | 23 ++
 rtl/ram_arb_grant.sv | 31 +++
 rtl/ram_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared constants and types for the data-RAM arbiter.
// Used by ram_arbiter and ram_arb_grant.
package ram_arbiter_pkg;

  localparam int MEM_WORDS = 7840;
  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 13;

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);

  typedef logic port_id_t;

  typedef struct packed {
    logic     pending;
    port_id_t owner;
    logic     oor;
  } rsp_pipe_t;

  function automatic logic in_range(logic [ADDR_W-1:0] a);
    return a < MEM_LIMIT;
  endfunction

endpackage

// File: rtl/ram_arb_grant.sv
// ram_arb_grant: two-input arbiter producing a one-hot grant.
// RAM_ARBITER_ROUND_ROBIN_EN selects round-robin, else port 0 priority.
module ram_arb_grant
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  port_id_t   last_i,
  output logic [1:0] gnt_o
);

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  always_comb begin
    gnt_o = valid_i;
    // On a tie the port that did not win last time goes next
    if (valid_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_last;
  assign unused_last = last_i;

  always_comb begin
    gnt_o = valid_i;
    if (valid_i[0]) begin
      gnt_o = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port data RAM between two requesters.
// Build option: RAM_ARBITER_ROUND_ROBIN_EN enables round-robin grants.
module ram_arbiter
  import ram_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_out
);

  logic [1:0]        vld;
  logic [1:0]        gnt;
  port_id_t          last;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_ok;
  rsp_pipe_t         pipe_d, pipe_q;
  logic [1:0]        rv_d, rv_q;
  logic [1:0]        re_d, re_q;
  logic [DATA_W-1:0] rd0_d, rd0_q;
  logic [DATA_W-1:0] rd1_d, rd1_q;

  // Reset masks the valids so nothing is granted or written
  assign vld = reset ? 2'b00 : {req1_valid, req0_valid};

  ram_arb_grant u_grant (
    .valid_i (vld),
    .last_i  (last),
    .gnt_o   (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  port_id_t last_d, last_q;

  always_comb begin
    last_d = last_q;
    if (|gnt) begin
      last_d = gnt[1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

  assign last = last_q;
`else
  assign last = 1'b1;
`endif

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    unique case (1'b1)
      gnt[0]: begin
        sel_wr    = req0_write;
        sel_addr  = req0_addr;
        sel_wdata = req0_wdata;
      end
      gnt[1]: begin
        sel_wr    = req1_write;
        sel_addr  = req1_addr;
        sel_wdata = req1_wdata;
      end
      default: ;
    endcase
  end

  assign sel_ok      = in_range(sel_addr);
  assign ram_address = sel_addr;
  assign ram_in      = sel_wdata;
  assign ram_write   = (|gnt) & sel_wr & sel_ok;

  always_comb begin
    pipe_d         = '0;
    pipe_d.pending = (|gnt) & ~sel_wr;
    pipe_d.owner   = gnt[1];
    pipe_d.oor     = ~sel_ok;
  end

  // ram_out carries the read word one edge after acceptance
  always_comb begin
    rv_d  = 2'b00;
    re_d  = re_q;
    rd0_d = rd0_q;
    rd1_d = rd1_q;
    if (pipe_q.pending) begin
      rv_d[pipe_q.owner] = 1'b1;
      re_d[pipe_q.owner] = pipe_q.oor;
      if (pipe_q.owner) rd1_d = pipe_q.oor ? '0 : ram_out;
      else              rd0_d = pipe_q.oor ? '0 : ram_out;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_q <= '0;
      rv_q   <= 2'b00;
      re_q   <= 2'b00;
      rd0_q  <= '0;
      rd1_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      rv_q   <= rv_d;
      re_q   <= re_d;
      rd0_q  <= rd0_d;
      rd1_q  <= rd1_d;
    end
  end

  assign rsp0_valid = rv_q[0];
  assign rsp1_valid = rv_q[1];
  assign rsp0_err   = re_q[0];
  assign rsp1_err   = re_q[1];
  assign rsp0_rdata = rd0_q;
  assign rsp1_rdata = rd1_q;

endmodule
